// File: rtl/acc_writeback.sv
// -----------------------------------------------------------------------------
// acc_writeback
//   Downstream stage of the MAC array. Each lane's accumulator is requantized
//   to W bits (arithmetic right shift, optional ReLU, saturation), the lane
//   group is queued in a small FIFO, and the valid lanes are serialized one
//   byte per transfer to the output memory at an auto-incrementing address.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-low
//   acc_in_0..3 in  per-lane signed accumulators (ACC_W)
//   valid_in   in   per-lane result valid; a nonzero value captures a group
//   shift      in   right-shift amount, sampled with valid_in
//   relu_en    in   clamp negatives to 0, sampled with valid_in
//   start      in   1-cycle pulse: flush, load base_addr, clear overflow
//   base_addr  in   first write address, sampled on start
//   wr_valid   out  write request
//   wr_ready   in   memory accepts the write
//   wr_addr    out  write address
//   wr_data    out  write data (signed)
//   busy       out  results pending anywhere in the block
//   overflow   out  sticky: a lane group was dropped on a full FIFO
//   count      out  FIFO occupancy
// -----------------------------------------------------------------------------
module acc_writeback #(
   parameter int ACC_W  = 16,
   parameter int W      = 8,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ACC_W-1:0]         acc_in_0,
   input  logic [ACC_W-1:0]         acc_in_1,
   input  logic [ACC_W-1:0]         acc_in_2,
   input  logic [ACC_W-1:0]         acc_in_3,
   input  logic [3:0]               valid_in,
   input  logic [3:0]               shift,
   input  logic                     relu_en,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        base_addr,
   output logic                     wr_valid,
   input  logic                     wr_ready,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic [W-1:0]             wr_data,
   output logic                     busy,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int N_MACS = 4;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int LANE_W = $clog2(N_MACS);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

   typedef enum logic {IDLE, EMIT} state_t;

   function automatic logic [W-1:0] quantize(input logic [ACC_W-1:0] acc,
                                             input logic [3:0]       sh,
                                             input logic             relu);
      logic signed [ACC_W-1:0] v;
      v = $signed(acc) >>> sh;
      if (relu && v < 0) v = '0;
      if (v > SAT_HI)      v = SAT_HI;
      else if (v < SAT_LO) v = SAT_LO;
      return v[W-1:0];
   endfunction

   logic [ACC_W-1:0]      acc [N_MACS];
   assign acc[0] = acc_in_0;
   assign acc[1] = acc_in_1;
   assign acc[2] = acc_in_2;
   assign acc[3] = acc_in_3;

   // Stage 1: quantized lane group
   logic                  s1_valid;
   logic [N_MACS-1:0]     s1_mask;
   logic [N_MACS*W-1:0]   s1_data;

   // FIFO
   logic [N_MACS-1:0]     mem_mask [DEPTH];
   logic [N_MACS*W-1:0]   mem_data [DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;

   // Output side
   state_t                state_q, state_d;
   logic [N_MACS-1:0]     buf_mask;
   logic [N_MACS*W-1:0]   buf_data;
   logic [N_MACS-1:0]     low_bit;
   logic [LANE_W-1:0]     sel;
   logic                  last_lane, xfer, pop, push_ok;

   // NOTE: sequential state uses non-blocking assignments so every register
   // sees the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_mask  <= '0;
         s1_data  <= '0;
      end else if (start) begin
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= |valid_in;
         if (|valid_in) begin
            s1_mask <= valid_in;
            for (int i = 0; i < N_MACS; i++)
               s1_data[i*W +: W] <= quantize(acc[i], shift, relu_en);
         end
      end
   end

   // Lowest remaining lane: two's-complement isolates the least significant set bit.
   assign low_bit   = buf_mask & (~buf_mask + 1'b1);
   assign last_lane = (buf_mask == low_bit);
   assign xfer      = (state_q == EMIT) && wr_ready;

   always_comb begin
      sel = '0;
      for (int i = N_MACS - 1; i >= 0; i--)
         if (buf_mask[i]) sel = LANE_W'(i);
   end

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: if (count != '0) begin
            pop     = 1'b1;
            state_d = EMIT;
         end
         EMIT: if (xfer && last_lane) begin
            if (count != '0) pop = 1'b1;   // refill with no bubble
            else             state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (start) begin
         state_d = IDLE;
         pop     = 1'b0;
      end
   end

   // A full FIFO still takes the entry when the head leaves in the same cycle.
   assign push_ok = s1_valid && !start && ((count < FULL) || pop);

   // NOTE: the FIFO storage has no reset; occupancy and pointers alone define
   // which entries are meaningful, so clearing the array would be wasted logic.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_mask[wr_ptr] <= s1_mask;
         mem_data[wr_ptr] <= s1_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         state_q  <= IDLE;
         buf_mask <= '0;
         buf_data <= '0;
         wr_addr  <= '0;
         overflow <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_addr  <= base_addr;
            overflow <= 1'b0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push_ok) - CNT_W'(pop);
            if (xfer) wr_addr <= wr_addr + 1'b1;
            if (s1_valid && !push_ok) overflow <= 1'b1;
         end
         if (pop) begin
            buf_mask <= mem_mask[rd_ptr];
            buf_data <= mem_data[rd_ptr];
         end else if (xfer) begin
            buf_mask <= buf_mask & ~low_bit;
         end
      end
   end

   assign wr_valid = (state_q == EMIT);
   assign wr_data  = wr_valid ? buf_data[sel*W +: W] : '0;
   assign busy     = s1_valid || (count != '0) || (state_q == EMIT);

endmodule
